// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer.
// Latency: n/a (types, constants and a pure helper only).
// Backpressure: n/a.
package fetch_pkg;

   localparam int HB_DEPTH = 3;

   typedef logic [15:0] halfword_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DROP = 2'd3
   } fetch_state_e;

   // An RVC parcel is any halfword whose low two bits are not 2'b11.
   function automatic logic is_rvc(input halfword_t hw);
      return hw[1:0] != 2'b11;
   endfunction

endpackage

// File: rtl/fetch_align_ctrl_if.sv
// Bundles the fetch sequencer's memory, redirect and decode-side signals.
// Latency: n/a (wiring only).
// Backpressure: imem_req_ready throttles requests, ins_ready throttles instructions.
// master = fetch sequencer side, slave = memory/decode/resolver side.
interface fetch_align_ctrl_if;

   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        jump_en_l1;
   logic [31:0] jump_addr_l1;
   logic        jump_en_l2;
   logic [31:0] jump_addr_l2;
   logic        ins_valid;
   logic        ins_ready;
   logic [31:0] ins_data;
   logic [31:0] ins_pc;
   logic        ins_is_c;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  jump_en_l1, jump_addr_l1, jump_en_l2, jump_addr_l2,
      output ins_valid, ins_data, ins_pc, ins_is_c,
      input  ins_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output jump_en_l1, jump_addr_l1, jump_en_l2, jump_addr_l2,
      input  ins_valid, ins_data, ins_pc, ins_is_c,
      output ins_ready
   );

endinterface

// File: rtl/fetch_hw_buf.sv
// 3-entry halfword shift buffer; hb0 is always the oldest halfword.
// Latency: push visible the cycle after the push edge; pop/push may share a cycle.
// Backpressure: none internally; the caller only pushes when room is guaranteed.
// Ports: flush (clear all), pop1/pop2 (drop oldest 1/2), push1 (append push_dat[31:16]),
//        push2 (append push_dat[15:0] then [31:16]); hb0/hb1/cnt current, cnt_nxt post-update.
module fetch_hw_buf
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        push1,
   input  logic        push2,
   input  logic        pop1,
   input  logic        pop2,
   input  logic [31:0] push_dat,
   output halfword_t   hb0,
   output halfword_t   hb1,
   output logic [1:0]  cnt,
   output logic [1:0]  cnt_nxt
);

   halfword_t  hb_q [HB_DEPTH];
   halfword_t  hb_d [HB_DEPTH];
   logic [1:0] cnt_q;
   logic [1:0] cnt_d;
   logic [1:0] base;

   // Pop first, then append behind whatever survives. Vacated slots are
   // zero-filled so an empty buffer presents an all-zero instruction.
   always_comb begin
      hb_d  = hb_q;
      cnt_d = cnt_q;
      base  = cnt_q;
      if (flush) begin
         for (int i = 0; i < HB_DEPTH; i++) hb_d[i] = '0;
         cnt_d = 2'd0;
      end else begin
         if (pop2) begin
            hb_d[0] = hb_q[2];
            hb_d[1] = '0;
            hb_d[2] = '0;
            base    = cnt_q - 2'd2;
         end else if (pop1) begin
            hb_d[0] = hb_q[1];
            hb_d[1] = hb_q[2];
            hb_d[2] = '0;
            base    = cnt_q - 2'd1;
         end
         for (int i = 0; i < HB_DEPTH; i++) begin
            if (push1 && i == int'(base)) hb_d[i] = push_dat[31:16];
            if (push2 && i == int'(base)) hb_d[i] = push_dat[15:0];
            if (push2 && i == int'(base) + 1) hb_d[i] = push_dat[31:16];
         end
         if (push2)      cnt_d = base + 2'd2;
         else if (push1) cnt_d = base + 2'd1;
         else            cnt_d = base;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < HB_DEPTH; i++) hb_q[i] <= '0;
         cnt_q <= 2'd0;
      end else begin
         for (int i = 0; i < HB_DEPTH; i++) hb_q[i] <= hb_d[i];
         cnt_q <= cnt_d;
      end
   end

   assign hb0     = hb_q[0];
   assign hb1     = hb_q[1];
   assign cnt     = cnt_q;
   assign cnt_nxt = cnt_d;

endmodule

// File: rtl/fetch_align_ctrl.sv
// RV32IC fetch sequencer: word-aligned imem requests, 16/32-bit instruction extraction, L1/L2 redirects.
// Latency: redirect at T -> request at T+1; response edge -> ins_valid next cycle.
// Backpressure: ins_ready low holds ins_*; new requests only while the buffer will hold <=1 halfword.
// Ports: clk, rst_n (async active-low); bus (master modport) carries imem req/rsp, redirects, instruction out.
module fetch_align_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          XLEN     = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   fetch_align_ctrl_if.master  bus
);

   fetch_state_e   state_q;
   fetch_state_e   state_d;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] fetch_addr_q;
   logic            skip_lo_q;

   logic        redirect;
   logic [31:0] tgt;
   halfword_t   hb0;
   halfword_t   hb1;
   logic [1:0]  cnt;
   logic [1:0]  cnt_nxt;
   logic        cur_c;
   logic        complete;
   logic        ins_fire;
   logic        req_fire;
   logic        rsp_take;

   // L2 (execute) redirect outranks L1 (decode).
   assign redirect = bus.jump_en_l2 | bus.jump_en_l1;
   assign tgt      = bus.jump_en_l2 ? bus.jump_addr_l2 : bus.jump_addr_l1;

   assign cur_c    = is_rvc(hb0);
   assign complete = cur_c ? (cnt >= 2'd1) : (cnt >= 2'd2);
   assign ins_fire = bus.ins_valid & bus.ins_ready;
   assign req_fire = (state_q == REQ) & bus.imem_req_ready;
   // A response landing on a redirect cycle belongs to the old stream.
   assign rsp_take = (state_q == WAIT) & bus.imem_rsp_valid & ~redirect;

   assign bus.ins_valid      = complete & ~redirect;
   assign bus.ins_data       = cur_c ? {16'h0000, hb0} : {hb1, hb0};
   assign bus.ins_pc         = pc_q;
   // Gated on cnt so an empty (all-zero) buffer does not report a compressed op.
   assign bus.ins_is_c       = (cnt != 2'd0) & cur_c;
   assign bus.imem_req_valid = (state_q == REQ);
   assign bus.imem_req_addr  = fetch_addr_q;

   fetch_hw_buf u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (redirect),
      .push1    (rsp_take & skip_lo_q),
      .push2    (rsp_take & ~skip_lo_q),
      .pop1     (ins_fire & cur_c),
      .pop2     (ins_fire & ~cur_c),
      .push_dat (bus.imem_rsp_data),
      .hb0      (hb0),
      .hb1      (hb1),
      .cnt      (cnt),
      .cnt_nxt  (cnt_nxt)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            // Refill only when at most one halfword remains, so a whole word always fits.
            if (redirect || cnt_nxt <= 2'd1) state_d = REQ;
         end
         REQ: begin
            // An accepted request on a redirect cycle fetched the old address: drain it.
            if (redirect)      state_d = bus.imem_req_ready ? DROP : REQ;
            else if (req_fire) state_d = WAIT;
         end
         WAIT: begin
            if (bus.imem_rsp_valid) state_d = IDLE;
            else if (redirect)      state_d = DROP;
         end
         DROP: begin
            if (bus.imem_rsp_valid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pc_q         <= {RESET_PC[31:1], 1'b0};
         fetch_addr_q <= {RESET_PC[31:2], 2'b00};
         skip_lo_q    <= RESET_PC[1];
      end else begin
         state_q <= state_d;
         if (redirect) begin
            pc_q         <= {tgt[31:1], 1'b0};
            fetch_addr_q <= {tgt[31:2], 2'b00};
            skip_lo_q    <= tgt[1];
         end else begin
            if (ins_fire) pc_q <= pc_q + (cur_c ? 32'd2 : 32'd4);
            if (req_fire) fetch_addr_q <= fetch_addr_q + 32'd4;
            if (rsp_take) skip_lo_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_align_ctrl.sv
// Directed bench for fetch_align_ctrl: memory responses and redirects are driven cycle by cycle.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_fetch_align_ctrl;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   fetch_align_ctrl_if bus ();

   fetch_align_ctrl #(
      .RESET_PC (32'h0000_0100),
      .XLEN     (32)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, ".req_valid"}, {31'd0, bus.imem_req_valid}, 32'd0);
      chk({tag, ".req_addr"},  bus.imem_req_addr, 32'h0000_0100);
      chk({tag, ".ins_valid"}, {31'd0, bus.ins_valid}, 32'd0);
      chk({tag, ".ins_pc"},    bus.ins_pc, 32'h0000_0100);
      chk({tag, ".ins_data"},  bus.ins_data, 32'd0);
      chk({tag, ".ins_is_c"},  {31'd0, bus.ins_is_c}, 32'd0);
   endtask

   task automatic chk_ins(input string tag, input logic [31:0] dat, input logic [31:0] pc,
                          input logic is_c);
      chk({tag, ".valid"}, {31'd0, bus.ins_valid}, 32'd1);
      chk({tag, ".data"},  bus.ins_data, dat);
      chk({tag, ".pc"},    bus.ins_pc, pc);
      chk({tag, ".is_c"},  {31'd0, bus.ins_is_c}, {31'd0, is_c});
   endtask

   task automatic chk_req(input string tag, input logic [31:0] addr);
      chk({tag, ".req_valid"}, {31'd0, bus.imem_req_valid}, 32'd1);
      chk({tag, ".req_addr"},  bus.imem_req_addr, addr);
   endtask

   task automatic rsp(input logic [31:0] dat);
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = dat;
   endtask

   task automatic no_rsp();
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n = 1'b0;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
      bus.jump_en_l1     = 1'b0;
      bus.jump_addr_l1   = 32'h0;
      bus.jump_en_l2     = 1'b0;
      bus.jump_addr_l2   = 32'h0;
      bus.ins_ready      = 1'b0;

      // ---- 1: reset, then 32-bit op followed by two compressed ops ----
      tick();
      tick();
      chk_rst("rst");
      rst_n = 1'b1;
      bus.imem_req_ready = 1'b1;
      tick();
      chk_req("t1.first_req", 32'h0000_0100);
      tick();
      chk("t1.wait_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
      rsp(32'h00A0_0513);
      tick();
      no_rsp();
      chk_ins("t1.i0", 32'h00A0_0513, 32'h0000_0100, 1'b0);
      chk("t1.idle_cnt2", {31'd0, bus.imem_req_valid}, 32'd0);
      bus.ins_ready = 1'b1;
      tick();
      bus.ins_ready = 1'b0;
      chk("t1.empty", {31'd0, bus.ins_valid}, 32'd0);
      chk_req("t1.req2", 32'h0000_0104);
      tick();
      rsp(32'h4501_4501);
      tick();
      no_rsp();
      chk_ins("t1.i1", 32'h0000_4501, 32'h0000_0104, 1'b1);
      bus.ins_ready = 1'b1;
      tick();
      bus.ins_ready = 1'b0;
      bus.imem_req_ready = 1'b0;
      chk_ins("t1.i2", 32'h0000_4501, 32'h0000_0106, 1'b1);
      chk_req("t1.req3", 32'h0000_0108);
      tick();

      // ---- 2: straddling 32-bit op at 0x202 ----
      bus.jump_en_l1   = 1'b1;
      bus.jump_addr_l1 = 32'h0000_0200;
      #1;
      chk("t2.redirect_masks_valid", {31'd0, bus.ins_valid}, 32'd0);
      tick();
      bus.jump_en_l1 = 1'b0;
      chk_req("t2.req", 32'h0000_0200);
      chk("t2.flushed", {31'd0, bus.ins_valid}, 32'd0);
      bus.imem_req_ready = 1'b1;
      tick();
      rsp(32'h0513_4501);
      tick();
      no_rsp();
      chk_ins("t2.c", 32'h0000_4501, 32'h0000_0200, 1'b1);
      bus.ins_ready = 1'b1;
      tick();
      chk("t2.partial_not_valid", {31'd0, bus.ins_valid}, 32'd0);
      chk_req("t2.req2", 32'h0000_0204);
      tick();
      rsp(32'h1234_00A0);
      tick();
      no_rsp();
      chk_ins("t2.straddle", 32'h00A0_0513, 32'h0000_0202, 1'b0);
      tick();
      bus.ins_ready = 1'b0;
      chk_ins("t2.leftover", 32'h0000_1234, 32'h0000_0206, 1'b1);

      // ---- 3: L1 redirect while a response is outstanding ----
      tick();
      bus.imem_req_ready = 1'b0;
      bus.jump_en_l1     = 1'b1;
      bus.jump_addr_l1   = 32'h0000_0302;
      #1;
      chk("t3.redirect_masks_valid", {31'd0, bus.ins_valid}, 32'd0);
      tick();
      bus.jump_en_l1 = 1'b0;
      rsp(32'hDEAD_BEEF);
      chk("t3.drop_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
      chk("t3.pc_tgt", bus.ins_pc, 32'h0000_0302);
      tick();
      no_rsp();
      chk("t3.stale_dropped", {31'd0, bus.ins_valid}, 32'd0);
      tick();
      chk_req("t3.req", 32'h0000_0300);
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready = 1'b0;
      rsp(32'h4505_0001);
      tick();
      no_rsp();
      chk_ins("t3.skip_lo", 32'h0000_4505, 32'h0000_0302, 1'b1);

      // ---- 4: simultaneous L1/L2 with decode ready ----
      bus.ins_ready    = 1'b1;
      bus.jump_en_l1   = 1'b1;
      bus.jump_addr_l1 = 32'h0000_0400;
      bus.jump_en_l2   = 1'b1;
      bus.jump_addr_l2 = 32'h0000_0500;
      #1;
      chk("t4.valid_low", {31'd0, bus.ins_valid}, 32'd0);
      tick();
      bus.jump_en_l1 = 1'b0;
      bus.jump_en_l2 = 1'b0;
      bus.ins_ready  = 1'b0;
      chk("t4.pc_l2", bus.ins_pc, 32'h0000_0500);
      chk_req("t4.req_l2", 32'h0000_0500);

      // ---- 5: backpressure with a full buffer ----
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready = 1'b0;
      rsp(32'h4511_4511);
      tick();
      no_rsp();
      chk_ins("t5.a", 32'h0000_4511, 32'h0000_0500, 1'b1);
      bus.ins_ready = 1'b1;
      tick();
      bus.ins_ready = 1'b0;
      chk_req("t5.refill", 32'h0000_0504);
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready = 1'b0;
      rsp(32'h4522_4522);
      tick();
      no_rsp();
      for (int i = 0; i < 5; i++) begin
         chk("t5.hold_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
         chk_ins("t5.hold", 32'h0000_4511, 32'h0000_0502, 1'b1);
         tick();
      end
      bus.ins_ready = 1'b1;
      tick();
      chk_ins("t5.b", 32'h0000_4522, 32'h0000_0504, 1'b1);
      chk("t5.cnt2_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
      tick();
      bus.ins_ready = 1'b0;
      chk("t5.pc_c", bus.ins_pc, 32'h0000_0506);
      chk_req("t5.reissue", 32'h0000_0508);

      // ---- 6: reset asserted while waiting for a response ----
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_rst("t6.rst");
      tick();
      rst_n = 1'b1;
      rsp(32'h1111_1111);
      tick();
      no_rsp();
      chk("t6.late_rsp_ignored", {31'd0, bus.ins_valid}, 32'd0);
      chk_req("t6.req", 32'h0000_0100);
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready = 1'b0;
      rsp(32'h00A0_0513);
      tick();
      no_rsp();
      chk_ins("t6.first", 32'h00A0_0513, 32'h0000_0100, 1'b0);

      // ---- address wrap at the top of memory ----
      bus.jump_en_l2   = 1'b1;
      bus.jump_addr_l2 = 32'hFFFF_FFFE;
      tick();
      bus.jump_en_l2 = 1'b0;
      chk_req("wrap.req", 32'hFFFF_FFFC);
      chk("wrap.pc", bus.ins_pc, 32'hFFFF_FFFE);
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready = 1'b0;
      rsp(32'h4501_0513);
      tick();
      no_rsp();
      chk_ins("wrap.ins", 32'h0000_4501, 32'hFFFF_FFFE, 1'b1);
      bus.ins_ready = 1'b1;
      tick();
      bus.ins_ready = 1'b0;
      chk("wrap.pc0", bus.ins_pc, 32'h0000_0000);
      chk_req("wrap.req0", 32'h0000_0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_align_ctrl.md
Name: fetch_align_ctrl

Overview:
- Instruction-fetch sequencer for the RV32IC 5-stage core.
- Issues word-aligned requests to the instruction memory port and holds returned words in a 3-halfword buffer.
- Extracts one aligned 16- or 32-bit instruction per handshake, including 32-bit instructions that straddle a word boundary.
- Applies L1/L2 redirects with L2 priority (same rule as the combinational PC selector), flushing the buffer and discarding any in-flight response.

Parameters:
RESET_PC  32'h0000_0000  first fetch PC after reset; bit0 must be 0
XLEN  32  address/data width; only 32 is supported

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  word-aligned fetch address, bits[1:0]=00
imem_rsp_valid  input  1  response word valid; arrives in order, >=1 cycle after acceptance
imem_rsp_data  input  32  response word, little-endian halfwords
jump_en_l1  input  1  redirect from L1 (decode-stage) resolver
jump_addr_l1  input  32  L1 target, halfword aligned
jump_en_l2  input  1  redirect from L2 (execute-stage) resolver; wins over L1
jump_addr_l2  input  32  L2 target
ins_valid  output  1  complete instruction available
ins_ready  input  1  decode accepts instruction
ins_data  output  32  instruction; upper 16 bits are zero when compressed
ins_pc  output  32  PC of ins_data
ins_is_c  output  1  1 if ins_data[1:0] != 2'b11

Behaviour:
- redirect = jump_en_l2 | jump_en_l1.
- tgt = jump_en_l2 ? jump_addr_l2 : jump_addr_l1. tgt bit0 is ignored.
- Buffer:
  - hb[0..2] halfwords, cnt 0..3; hb[0] sits at ins_pc.
  - Instruction complete when cnt>=1 and hb[0][1:0]!=11, or cnt>=2 and hb[0][1:0]==11.
  - ins_valid = complete & ~redirect. ins_data/ins_is_c/ins_pc are combinational from hb[0], hb[1] and the pc register.
- Handshake (ins_valid & ins_ready):
  - Shift out 1 halfword (compressed) or 2 (32-bit).
  - pc += 2 or 4, modulo 2^32.
  - ins_data/ins_pc hold stable while ins_valid & ~ins_ready.
- Fetch FSM states: IDLE, REQ, WAIT, DROP.
  - IDLE -> REQ when cnt_next<=1 and no redirect. imem_req_valid = (state==REQ), registered.
  - REQ: when imem_req_ready, go to WAIT; fetch_addr += 4.
  - WAIT: when imem_rsp_valid, append the word to the buffer and go to IDLE.
    - Normally append both halfwords.
    - If skip_lo is set, append only the upper halfword, then clear skip_lo.
    - The cnt<=1 rule guarantees the buffer cannot overflow.
  - DROP: when imem_rsp_valid, discard the word and go to IDLE.
- Redirect (any state, highest priority):
  - cnt<=0, pc<=tgt, fetch_addr<={tgt[31:2],00}, skip_lo<=tgt[1].
  - No instruction is consumed that cycle.
  - REQ stays REQ with the new address next cycle. The memory port allows address change before acceptance. If ready was also high that cycle, the accepted request goes to DROP.
  - WAIT goes to DROP.
  - A response arriving in the same cycle as a redirect is discarded. From WAIT or DROP the next state is IDLE.
  - IDLE issues REQ next cycle.
- Latency: redirect at T -> req_valid at T+1. With ready at T+1 and rsp at T+2, ins_valid at T+3.
- A response is buffered on its arrival edge; ins_valid is asserted the following cycle.
- Reset values:
  - state=IDLE, cnt=0, pc=RESET_PC, fetch_addr={RESET_PC[31:2],00}, skip_lo=RESET_PC[1].
  - imem_req_valid=0, imem_req_addr={RESET_PC[31:2],00}, ins_valid=0, ins_pc=RESET_PC, ins_data=0, ins_is_c=0.
  - First request is issued 1 cycle after reset release.
- Address wrap: fetch_addr 0xFFFF_FFFC+4 -> 0x0000_0000. No fault is raised.

Decomposition:
- fetch_pkg:
  - fetch_state_e (IDLE/REQ/WAIT/DROP).
  - halfword_t.
  - function is_rvc(halfword_t).
  - localparam HB_DEPTH=3.
- Sub-module fetch_hw_buf: 3-entry halfword shift buffer. Controls: push1/push2, pop1/pop2, flush. Exposes hb0, hb1, cnt.
- The FSM and PC arithmetic stay in fetch_align_ctrl.

Test Plan:
1. Reset, RESET_PC=0x100, ready=1, mem returns 0x00A0_0513 (32-bit) then 0x4501_4501 -> req addr 0x100 at cycle 1; ins_data=0x00A00513, ins_pc=0x100, is_c=0; then two compressed 0x4501 at pc 0x104 and 0x106.
2. Straddle: word@0x200 = {0x0513,0x4501} (upper,lower), word@0x204 = {0x1234,0x00A0} -> 0x4501 @0x200 is_c=1; then 0x00A00513 @0x202 is_c=0; then 0x1234 halfword remains with cnt=1 at pc 0x206.
3. Redirect while in WAIT: jump_en_l1=1, addr 0x302; stale rsp arrives next cycle -> rsp discarded; next req addr 0x300; lower half skipped; first ins_pc=0x302.
4. Simultaneous jump_en_l1 (0x400) and jump_en_l2 (0x500), with ins_valid&ins_ready same cycle -> ins_valid=0 that cycle; req addr 0x500; no pc advance.
5. Backpressure: ins_ready=0 for 5 cycles with cnt=3 -> no new req issued (state IDLE); ins_data/ins_pc stable; req reissued after cnt drops to <=1.
6. Assert rst_n low while in WAIT -> outputs return to reset values immediately; the late rsp after release is ignored (state IDLE); first req at 0x100.
